// File: rtl/led_matrix_scan_ctrl.sv
// Row-scanned 9x8 LED matrix driver: per-row slot with a dark lead-in, registered outputs.
// Optional ping-pong frame buffers selected by `define LED_DOUBLE_BUFFER_EN.
`timescale 1ns/1ps
module led_matrix_scan_ctrl #(
  parameter int ROW_PERIOD   = 27000,
  parameter int BLANK_CYCLES = 270
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [7:0] led_col,
  output logic [8:0] led_row
);

  localparam int CNT_W = (ROW_PERIOD > 1) ? $clog2(ROW_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ROW_PERIOD - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_t;

  slot_state_t      state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       row_r, row_s;
  logic             pending_r, pending_s;
  logic             wrap_frame_s;
  logic             swap_s;
  logic             drive_enter_s;
  logic [7:0]       front_row_s;
  logic [8:0]       led_row_r, led_row_s;
  logic [7:0]       led_col_r, led_col_s;
  logic             swap_ack_r;
  logic             frame_start_r;
  logic [7:0]       buf_a_r [9];
`ifdef LED_DOUBLE_BUFFER_EN
  logic [7:0]       buf_b_r [9];
  logic             front_sel_r;
`endif

  assign led_row     = led_row_r;
  assign led_col     = led_col_r;
  assign swap_ack    = swap_ack_r;
  assign frame_start = frame_start_r;

  // Slot state, counters, pending flag and output registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_BLANK;
      cnt_r         <= '0;
      row_r         <= 4'd0;
      pending_r     <= 1'b0;
      led_row_r     <= 9'd0;
      led_col_r     <= 8'd0;
      swap_ack_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      row_r         <= row_s;
      pending_r     <= pending_s;
      led_row_r     <= led_row_s;
      led_col_r     <= led_col_s;
      swap_ack_r    <= swap_s;
      frame_start_r <= wrap_frame_s;
    end
  end

  // Next-state and next-output logic; outputs are precomputed so the registers match cnt/row
  always_comb begin
    cnt_s         = cnt_r + CNT_W'(1);
    row_s         = row_r;
    state_s       = state_r;
    wrap_frame_s  = 1'b0;
    swap_s        = 1'b0;
    pending_s     = pending_r | swap_req;
    drive_enter_s = 1'b0;
    led_row_s     = 9'd0;
    led_col_s     = 8'd0;

    if (cnt_r == CNT_LAST) begin
      cnt_s = '0;
      if (row_r >= 4'd8) begin
        row_s        = 4'd0;
        wrap_frame_s = 1'b1;
      end else begin
        row_s = row_r + 4'd1;
      end
    end else begin
      row_s = row_r;
    end

    case (state_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_s       = ST_DRIVE;
          drive_enter_s = 1'b1;
        end else begin
          state_s = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_BLANK;
        end else begin
          state_s = ST_DRIVE;
        end
      end
      default: begin
        state_s = ST_BLANK;
      end
    endcase

    // Collapse all requests since the last boundary into one swap
    if (wrap_frame_s && pending_s) begin
      swap_s    = 1'b1;
      pending_s = 1'b0;
    end else begin
      swap_s = 1'b0;
    end

    if (state_s == ST_DRIVE) begin
      led_row_s = 9'd1 << row_s;
      led_col_s = drive_enter_s ? front_row_s : led_col_r;
    end else begin
      led_row_s = 9'd0;
      led_col_s = 8'd0;
    end
  end

`ifdef LED_DOUBLE_BUFFER_EN
  // Front-row lookup from whichever buffer is currently displayed
  always_comb begin
    if (front_sel_r) begin
      front_row_s = buf_b_r[row_r];
    end else begin
      front_row_s = buf_a_r[row_r];
    end
  end

  // Writes go to the back buffer; a write on the swap edge lands before the exchange
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        buf_a_r[i] <= 8'h00;
        buf_b_r[i] <= 8'h00;
      end
      front_sel_r <= 1'b0;
    end else begin
      if (wr_en && (wr_row <= 4'd8)) begin
        if (front_sel_r) begin
          buf_a_r[wr_row] <= wr_data;
        end else begin
          buf_b_r[wr_row] <= wr_data;
        end
      end
      if (swap_s) begin
        front_sel_r <= ~front_sel_r;
      end
    end
  end
`else
  // Single buffer serves as front and back; captured at DRIVE entry only
  always_comb begin
    front_row_s = buf_a_r[row_r];
  end

  // Frame buffer writes; out-of-range rows are dropped
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        buf_a_r[i] <= 8'h00;
      end
    end else begin
      if (wr_en && (wr_row <= 4'd8)) begin
        buf_a_r[wr_row] <= wr_data;
      end
    end
  end
`endif

endmodule

// File: doc/led_matrix_scan_ctrl.md
LED_MATRIX_SCAN_CTRL -- requirements
Module: led_matrix_scan_ctrl

Interface
REQ-001 The module SHALL have parameter ROW_PERIOD, default 27000, meaning clock cycles per row slot (1 ms at 27 MHz).
REQ-002 The module SHALL have parameter BLANK_CYCLES, default 270, meaning dark cycles at the start of each row slot; legal range 1 to ROW_PERIOD-1.
REQ-003 The module SHALL have port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port wr_en, input, 1 bit: frame-buffer write strobe.
REQ-006 The module SHALL have port wr_row, input, 4 bits: target row, 0..8.
REQ-007 The module SHALL have port wr_data, input, 8 bits: column pattern for wr_row.
REQ-008 The module SHALL have port swap_req, input, 1 bit: request to present the back buffer at the next frame boundary.
REQ-009 The module SHALL have port swap_ack, output, 1 bit: one-cycle pulse when the swap takes effect.
REQ-010 The module SHALL have port frame_start, output, 1 bit: one-cycle pulse at the start of row 0.
REQ-011 The module SHALL have port led_col, output, 8 bits: column drive, 1 = lit.
REQ-012 The module SHALL have port led_row, output, 9 bits: one-hot row select, all zero when blank.

Function
REQ-013 The module SHALL keep slot counter cnt over 0..ROW_PERIOD-1; at ROW_PERIOD-1 it returns to 0, otherwise it increments.
REQ-014 The module SHALL keep row_idx over 0..8, advancing when cnt wraps; 8 wraps to 0, and values 9..15 never occur.
REQ-015 The module SHALL implement the slot FSM states: BLANK while cnt < BLANK_CYCLES, DRIVE while cnt >= BLANK_CYCLES.
REQ-016 In BLANK, the module SHALL drive led_row = 0 and led_col = 0.
REQ-017 In DRIVE, the module SHALL drive led_row = 9'd1 << row_idx and led_col = front[row_idx].
REQ-018 led_row and led_col SHALL be registers whose values correspond to the current cnt and row_idx, with no combinational glitch on the outputs.
REQ-019 The module SHALL capture front[row_idx] when entering DRIVE; a buffer change mid-DRIVE SHALL NOT alter led_col until the next slot.
REQ-020 The module SHALL assert frame_start in the cycle where cnt = 0 and row_idx = 0.
REQ-021 When wr_en = 1 and wr_row <= 8, the module SHALL write wr_data into back[wr_row] on that edge; wr_row >= 9 SHALL be ignored with no side effect.
REQ-022 The module SHALL set a pending-swap flag on swap_req = 1; repeated requests before the swap SHALL collapse into one swap.
REQ-023 On the edge where row_idx wraps 8->0 with the flag set (or with swap_req = 1 on that edge), the module SHALL exchange front and back, clear the flag, and assert swap_ack in the following cycle together with frame_start.
REQ-024 A write on the swap edge SHALL land in the pre-swap back buffer, so it becomes visible in the frame that is starting.
REQ-025 A swap_req arriving in the swap_ack cycle SHALL set the flag for the next frame boundary.
REQ-026 swap_ack SHALL never be asserted outside a frame_start cycle.

Reset
REQ-027 While rst_n = 0, the module SHALL force cnt = 0, row_idx = 0, state BLANK, led_col = 0, led_row = 0, swap_ack = 0, frame_start = 0, and the pending flag to 0.
REQ-028 Reset SHALL clear both frame buffers to 0x00 and select buffer A as front.
REQ-029 After rst_n deasserts, the module SHALL complete the first slot as row 0 starting at cnt = 0; frame_start is NOT asserted for this first frame.
REQ-030 Reset asserted mid-frame or mid-DRIVE SHALL blank the outputs immediately (asynchronously) and discard any pending swap.

Configuration
REQ-031 With LED_DOUBLE_BUFFER_EN defined, the module SHALL provide two 9x8 buffers and behave as in REQ-021 to REQ-026.
REQ-032 Without LED_DOUBLE_BUFFER_EN, the module SHALL provide one buffer that serves as both front and back; writes SHALL take effect at the next DRIVE entry, and swap_req SHALL produce swap_ack at the next frame boundary with no other effect.

Verification (ROW_PERIOD=20, BLANK_CYCLES=4)
REQ-033 Reset, then free-run 200 cycles -> led_row steps 0x001, 0x002, ..., 0x100, 0x001; each slot shows 4 blank cycles then 16 drive cycles; led_col = 0x00 throughout.
REQ-034 Write row 3 = 0xAA, pulse swap_req -> no change until the 8->0 wrap; swap_ack and frame_start coincide; row 3 drive shows led_col = 0xAA.
REQ-035 Write wr_row = 9 with data 0xFF, then swap -> all rows show 0x00.
REQ-036 Write row 0 = 0x55 on the swap edge -> row 0 of the new frame shows 0x55.
REQ-037 Assert rst_n = 0 at row 5, cnt = 10, with a swap pending -> outputs go to 0 immediately; after release, rows restart at 0 and no swap_ack occurs.
REQ-038 Without LED_DOUBLE_BUFFER_EN, write row 2 = 0x0F during row 2 DRIVE -> the current slot is unchanged; the next frame's row 2 shows 0x0F.
